// File: rtl/button_debounce_multi_pkg.sv
// dds_btn_pkg: default front-panel timing constants, ms_to_cycles() helper and the per-channel status struct
package dds_btn_pkg;
    localparam int CLK_HZ = 27_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int LONG_MS = 1000;
    localparam int REPEAT_MS = 200;
    function automatic int ms_to_cycles(input int ms);
        return ms * (CLK_HZ / 1000);
    endfunction
    typedef struct packed {
        logic pressed;
        logic press;
        logic release_p;
        logic long_p;
    } btn_status_t;
endpackage

// File: rtl/button_debounce_multi_if.sv
// button_debounce_multi_if: raw pins in, debounced level and press/release/long strobes out; master drives pins, slave is the conditioner
interface button_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_raw_i;
    logic [N_CH-1:0] pressed_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] long_o;
    modport master (output btn_raw_i, input pressed_o, press_o, release_o, long_o);
    modport slave (input btn_raw_i, output pressed_o, press_o, release_o, long_o);
endinterface

// File: rtl/button_debounce_multi_ch.sv
// btn_debounce_ch: one button channel (synchroniser, bounce filter, hold timer, autorepeat under BTN_AUTOREPEAT_EN); ports clkin_i, reset_i, btn_raw_i -> status_o
module btn_debounce_ch
    import dds_btn_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int LONG_PRESS_CYCLES = ms_to_cycles(LONG_MS),
    parameter int REPEAT_CYCLES = ms_to_cycles(REPEAT_MS)
) (
    input  logic        clkin_i,
    input  logic        reset_i,
    input  logic        btn_raw_i,
    output btn_status_t status_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic IDLE = ACTIVE_LOW != 0;
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("btn_debounce_ch: timing parameters must be >= 2");
    end
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    logic pressed_q, pressed_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
    logic s, flip, held_full;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep_q, rep_d;
`endif
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        s = sync_q[SYNC_STAGES-1] ^ IDLE;
        flip = (s != pressed_q) && (db_q == DW'(DEBOUNCE_CYCLES - 1));
        db_d = (s == pressed_q || flip) ? '0 : db_q + 1'b1;
        pressed_d = pressed_q ^ flip;
        press_d = flip & ~pressed_q;
        rel_d = flip & pressed_q;
        held_full = hold_q == HW'(LONG_PRESS_CYCLES);
        hold_d = !pressed_q ? '0 : held_full ? hold_q : hold_q + 1'b1;
        long_d = pressed_q & ~flip & (hold_q == HW'(LONG_PRESS_CYCLES - 1));
`ifdef BTN_AUTOREPEAT_EN
        rep_d = (pressed_q && held_full) ? ((rep_q == RW'(REPEAT_CYCLES - 1)) ? '0 : rep_q + 1'b1) : '0;
        long_d = long_d | (pressed_q & ~flip & held_full & (rep_q == RW'(REPEAT_CYCLES - 1)));
`endif
    end
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{IDLE}};
            db_q <= '0;
            hold_q <= '0;
            pressed_q <= 1'b0;
            press_q <= 1'b0;
            rel_q <= 1'b0;
            long_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_q <= '0;
`endif
        end else begin
            sync_q <= sync_d;
            db_q <= db_d;
            hold_q <= hold_d;
            pressed_q <= pressed_d;
            press_q <= press_d;
            rel_q <= rel_d;
            long_q <= long_d;
`ifdef BTN_AUTOREPEAT_EN
            rep_q <= rep_d;
`endif
        end
    end
    assign status_o = '{pressed: pressed_q, press: press_q, release_p: rel_q, long_p: long_q};
endmodule

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: N_CH independent button conditioners; ports clkin_i, reset_i, bus (slave: btn_raw_i in; pressed_o/press_o/release_o/long_o out); BTN_AUTOREPEAT_EN adds autorepeat long_o ticks
module button_debounce_multi
    import dds_btn_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int LONG_PRESS_CYCLES = ms_to_cycles(LONG_MS),
    parameter int REPEAT_CYCLES = ms_to_cycles(REPEAT_MS)
) (
    input logic clkin_i,
    input logic reset_i,
    button_debounce_multi_if.slave bus
);
    btn_status_t st [N_CH];
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .ACTIVE_LOW(ACTIVE_LOW),
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clkin_i(clkin_i),
            .reset_i(reset_i),
            .btn_raw_i(bus.btn_raw_i[i]),
            .status_o(st[i])
        );
    end
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            bus.pressed_o[c] = st[c].pressed;
            bus.press_o[c] = st[c].press;
            bus.release_o[c] = st[c].release_p;
            bus.long_o[c] = st[c].long_p;
        end
    end
endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: directed and random stimulus checked every cycle against a window-based behavioural model
module tb_button_debounce_multi;
    localparam int N = 2, SY = 2, DB = 16, LP = 64, RP = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    button_debounce_multi_if #(.N_CH(N)) bus ();
    button_debounce_multi #(
        .N_CH(N), .ACTIVE_LOW(1), .SYNC_STAGES(SY),
        .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP)
    ) dut (
        .clkin_i(clk),
        .reset_i(rst),
        .bus(bus)
    );
    int checks = 0, failures = 0, k = 0;
    logic dly [N][$];
    logic win [N][$];
    logic m_pr [N];
    int t0 [N];
    logic [N-1:0] e_pr, e_press, e_rel, e_long;
    int n_press [N], n_rel [N], n_long [N], last_press [N], last_rel [N], first_long [N];
    bit saw_both;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask
    task automatic clr();
        saw_both = 0;
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
            last_press[c] = -1; last_rel[c] = -1; first_long[c] = -1;
        end
    endtask
    task automatic model_edge(input logic [N-1:0] raw, input logic r);
        for (int c = 0; c < N; c++) begin
            logic s, prev, flip;
            int d;
            if (r) begin
                dly[c].delete();
                repeat (SY) dly[c].push_back(1'b1);
                win[c].delete();
                m_pr[c] = 1'b0;
                e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
            end else begin
                s = !dly[c].pop_front();
                dly[c].push_back(raw[c]);
                win[c].push_back(s);
                if (win[c].size() > DB) void'(win[c].pop_front());
                flip = win[c].size() == DB;
                for (int i = 0; i < win[c].size(); i++) if (win[c][i] == m_pr[c]) flip = 1'b0;
                prev = m_pr[c];
                m_pr[c] = prev ^ flip;
                e_press[c] = flip & !prev;
                e_rel[c] = flip & prev;
                if (e_press[c]) t0[c] = k;
                d = k - t0[c];
`ifdef BTN_AUTOREPEAT_EN
                e_long[c] = prev && m_pr[c] && (d == LP || (d > LP && (d - LP) % RP == 0));
`else
                e_long[c] = prev && m_pr[c] && d == LP;
`endif
            end
            e_pr[c] = m_pr[c];
        end
    endtask
    task automatic tick(input logic [N-1:0] raw, input logic r);
        bus.btn_raw_i = raw;
        rst = r;
        @(posedge clk);
        k++;
        model_edge(raw, r);
        #1;
        chk("pressed_o", int'(bus.pressed_o), int'(e_pr));
        chk("press_o", int'(bus.press_o), int'(e_press));
        chk("release_o", int'(bus.release_o), int'(e_rel));
        chk("long_o", int'(bus.long_o), int'(e_long));
        if (bus.press_o == 2'b11) saw_both = 1;
        for (int c = 0; c < N; c++) begin
            if (bus.press_o[c]) begin n_press[c]++; last_press[c] = k; end
            if (bus.release_o[c]) begin n_rel[c]++; last_rel[c] = k; end
            if (bus.long_o[c]) begin
                n_long[c]++;
                if (first_long[c] < 0) first_long[c] = k;
            end
        end
    endtask
    initial begin
        int start, tot_p, tot_r;
        logic lv;
        logic [N-1:0] lvl;
        int rem [N];
        bus.btn_raw_i = '1;
        for (int c = 0; c < N; c++) begin
            m_pr[c] = 1'b0;
            t0[c] = 0;
        end
        repeat (5) tick('1, 1'b1);
        clr();
        repeat (100) tick('1, 1'b0);
        chk("idle_press", n_press[0] + n_press[1], 0);
        chk("idle_release", n_rel[0] + n_rel[1], 0);
        chk("idle_long", n_long[0] + n_long[1], 0);
        tot_p = 0;
        tot_r = 0;
        for (int rep = 0; rep < 3; rep++) begin
            clr();
            lv = 1'b1;
            for (int i = 0; i < 10; i++) begin
                lv = ~lv;
                repeat ($urandom_range(1, 3)) tick({1'b1, lv}, 1'b0);
            end
            start = k;
            repeat (20) tick(2'b10, 1'b0);
            chk("bounce_press_lat", last_press[0] - start, 18);
            lv = 1'b0;
            for (int i = 0; i < 10; i++) begin
                lv = ~lv;
                repeat ($urandom_range(1, 3)) tick({1'b1, lv}, 1'b0);
            end
            start = k;
            repeat (30) tick('1, 1'b0);
            chk("bounce_release_lat", last_rel[0] - start, 18);
            chk("bounce_one_press", n_press[0], 1);
            chk("bounce_one_release", n_rel[0], 1);
            tot_p += n_press[0];
            tot_r += n_rel[0];
        end
        chk("bounce_total_press", tot_p, 3);
        chk("bounce_total_release", tot_r, 3);
        clr();
        start = k;
        repeat (100) tick(2'b10, 1'b0);
        chk("hold_press_lat", last_press[0] - start, 18);
        chk("hold_first_long", first_long[0] - start, 82);
`ifdef BTN_AUTOREPEAT_EN
        chk("hold_long_count", n_long[0], 3);
`else
        chk("hold_long_count", n_long[0], 1);
`endif
        repeat (40) tick('1, 1'b0);
        chk("hold_release", n_rel[0], 1);
        clr();
        repeat (64) tick(2'b10, 1'b0);
        repeat (30) tick('1, 1'b0);
        chk("release_at_terminal_long", n_long[0], 0);
        chk("release_at_terminal_rel", n_rel[0], 1);
        clr();
        repeat (65) tick(2'b10, 1'b0);
        repeat (30) tick('1, 1'b0);
        chk("release_after_terminal_long", n_long[0], 1);
        clr();
        repeat (15) tick(2'b10, 1'b0);
        repeat (30) tick('1, 1'b0);
        chk("glitch_press", n_press[0], 0);
        chk("glitch_level", int'(bus.pressed_o), 0);
        clr();
        repeat (50) tick(2'b00, 1'b0);
        chk("both_press", int'(saw_both), 1);
        clr();
        repeat (2) tick(2'b00, 1'b1);
        chk("reset_level", int'(bus.pressed_o), 0);
        repeat (30) tick('1, 1'b0);
        chk("reset_no_release", n_rel[0] + n_rel[1], 0);
        chk("reset_no_press", n_press[0] + n_press[1], 0);
        lvl = '1;
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 120);
                end
                rem[c]--;
            end
            tick(lvl, $urandom_range(0, 499) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- N-channel push-button conditioner for the DDS board front panel, running in the 27 MHz PLL reference domain.
- Per channel it:
  - synchronises the raw pin;
  - rejects contact bounce with a stability counter;
  - outputs a clean level, one-cycle press and release strobes, and a long-press strobe.
- Generalises the single-button bounce handling exercised during PLL bring-up to parametrised channel count, polarity and timing.

Parameters:
- N_CH, 4, number of button channels.
- ACTIVE_LOW, 1. 1: pin low = pressed. 0: pin high = pressed.
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 270000, consecutive stable cycles to accept a level change (10 ms at 27 MHz; ≥2).
- LONG_PRESS_CYCLES, 27000000, cycles held before the long-press strobe (1 s; ≥2).
- REPEAT_CYCLES, 5400000, autorepeat period (200 ms). Used only with the optional feature.

Ports:
- clkin_i, in, 1: system clock, 27 MHz.
- reset_i, in, 1: synchronous, active-high reset.
- btn_raw_i, in, N_CH: asynchronous raw button pins.
- pressed_o, out, N_CH: debounced level, 1 = pressed.
- press_o, out, N_CH: 1-cycle strobe on accepted press.
- release_o, out, N_CH: 1-cycle strobe on accepted release.
- long_o, out, N_CH: 1-cycle strobe when hold reaches LONG_PRESS_CYCLES (or on each autorepeat tick).

Behaviour:
- Reset:
  - Sync flops load the inactive pin level (1 if ACTIVE_LOW).
  - All counters are 0.
  - All outputs are 0.
  - Reset mid-bounce or mid-hold discards state. No strobes are emitted on reset deassert.
- Polarity: sample s = sync_out XOR ACTIVE_LOW, so s = 1 means pressed.
- Debounce counter (per channel):
  - Width $clog2(DEBOUNCE_CYCLES).
  - If s == pressed_o, the counter is cleared.
  - Otherwise it increments.
  - When it equals DEBOUNCE_CYCLES-1 with s still differing: pressed_o toggles on the next edge and the counter clears.
  - Any glitch back to the current level before then restarts the count from 0.
- Latency: from a clean pin edge to a pressed_o change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Strobes:
  - press_o and release_o are registered and high in the same cycle pressed_o changes (rise or fall respectively).
  - Never both high on one channel.
- Long press:
  - Hold counter is width $clog2(LONG_PRESS_CYCLES+1).
  - Counts each cycle while pressed_o = 1 and is cleared when pressed_o = 0.
  - long_o pulses once when the counter reaches LONG_PRESS_CYCLES-1, then the counter saturates. No further long strobes until release.
  - release_o still fires after a long press.
  - A release accepted in the same cycle the counter would hit terminal count suppresses long_o.
- Channels are fully independent. Simultaneous events on different channels each produce their own strobes in the same cycle.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: after the first long_o pulse, a repeat counter (width $clog2(REPEAT_CYCLES)) generates a further long_o pulse every REPEAT_CYCLES cycles while held. It is cleared on release or reset.
- Undefined: long_o is a single pulse per hold. REPEAT_CYCLES is ignored and no repeat logic is synthesised.

Decomposition:
- Package dds_btn_pkg holds:
  - default timing constants (CLK_HZ = 27_000_000, DEBOUNCE_MS, LONG_MS, REPEAT_MS);
  - a function ms_to_cycles();
  - a typedef for the per-channel status struct {pressed, press, release, long_p}.
- Sub-module btn_debounce_ch implements one channel (sync, debounce, hold counter). The top instantiates N_CH copies via generate.

Test Plan:
Bench parameters for all scenarios: N_CH=2, ACTIVE_LOW=1, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, LONG_PRESS_CYCLES=64, REPEAT_CYCLES=8.
- Reset release with pins idle high → all outputs 0 for 100 cycles, no strobes.
- Ch0 bounce: 10 toggles, 20 cycles low, 10 toggles, then high.
  - Exactly one press_o, 18 cycles after the low run starts.
  - Exactly one release_o, 18 cycles after the final high.
  - Repeat 3× → 3 press and 3 release strobes.
- Ch0 held low 100 cycles:
  - press_o at cycle 18;
  - long_o exactly once, 64 cycles later;
  - with BTN_AUTOREPEAT_EN, additional long_o every 8 cycles until release.
- Glitch: pin low for 15 cycles then high → no press_o, pressed_o stays 0.
- Both channels pressed in the same cycle → press_o = 2'b11 in one cycle. Reset asserted mid-hold → pressed_o = 0, no release_o emitted.
